// File: rtl/conv3x3_stream.sv
// Streaming 3x3 "valid" convolution over an IMG_W x IMG_H x CH image with run-time
// weights and bias, round-half-up shift, and clamping to an unsigned DW-bit result.
module conv3x3_stream #(
  parameter int unsigned IMG_W = 28,
  parameter int unsigned IMG_H = 28,
  parameter int unsigned CH    = 3,
  parameter int unsigned DW    = 8,
  parameter int unsigned WW    = 8,
  parameter int unsigned SHIFT = 6,
  parameter int unsigned RELU  = 1,
  localparam int unsigned NTAP  = 9 * CH,
  localparam int unsigned ACC_W = DW + WW + $clog2(NTAP) + 1,
  localparam int unsigned AW    = $clog2(NTAP + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  input  logic               w_we,
  input  logic [AW-1:0]      w_addr,
  input  logic [ACC_W-1:0]   w_data,
  input  logic               pix_valid,
  input  logic [CH*DW-1:0]   pix_in,
  output logic               out_valid,
  output logic [DW-1:0]      out_data,
  output logic               done
);

  localparam int unsigned PW   = DW + WW + 1;
  localparam int unsigned PXW  = CH * DW;
  localparam int unsigned CW   = $clog2(IMG_W);
  localparam int unsigned RW   = $clog2(IMG_H);
  localparam int unsigned RND  = (SHIFT > 0) ? (1 << (SHIFT - 1)) : 0;
  localparam int unsigned MAXV = (1 << DW) - 1;
  // Output is unsigned, so negatives floor at zero in either RELU mode.
  localparam logic [DW-1:0] NEG_CLAMP = (RELU != 0) ? '0 : '0;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                  state, state_d;
  logic [1:0]              drain_cnt, drain_cnt_d;
  logic                    busy_d, done_d;
  logic                    accept_c, frame_start_c, last_pix_c;

  logic [CW-1:0]           col;
  logic [RW-1:0]           row;
  logic [PXW-1:0]          lb1 [IMG_W];
  logic [PXW-1:0]          lb2 [IMG_W];
  logic [PXW-1:0]          win [3][3];
  logic                    win_valid;

  logic signed [WW-1:0]    wt [NTAP];
  logic signed [ACC_W-1:0] bias;

  logic signed [PW-1:0]    s1_prod [NTAP];
  logic                    s1_valid;
  logic signed [ACC_W-1:0] sum_c;
  logic signed [ACC_W-1:0] s2_acc;
  logic                    s2_valid;
  logic signed [ACC_W:0]   rnd_c, shifted_c;
  logic [DW-1:0]           sat_c;

  assign last_pix_c = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));

  // Frame control: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      drain_cnt <= drain_cnt_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // Frame control: next state; DRAIN covers the 3-stage pipeline flush
  always_comb begin
    state_d       = state;
    drain_cnt_d   = drain_cnt;
    busy_d        = busy;
    done_d        = 1'b0;
    accept_c      = 1'b0;
    frame_start_c = 1'b0;
    unique case (state)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d       = RUN;
          busy_d        = 1'b1;
          frame_start_c = 1'b1;
        end
      end
      RUN: begin
        accept_c = pix_valid;
        if (pix_valid && last_pix_c) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end
      end
      DRAIN: begin
        drain_cnt_d = drain_cnt + 2'd1;
        if (drain_cnt == 2'd2) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Raster position of the next accepted pixel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (frame_start_c) begin
      col <= '0;
      row <= '0;
    end else if (accept_c) begin
      if (col == CW'(IMG_W - 1)) begin
        col <= '0;
        row <= (row == RW'(IMG_H - 1)) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Line buffers and 3x3 window; column 2 of the window is the newest
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < IMG_W; i++) begin
        lb1[i] <= '0;
        lb2[i] <= '0;
      end
      for (int ky = 0; ky < 3; ky++) begin
        for (int kx = 0; kx < 3; kx++) begin
          win[ky][kx] <= '0;
        end
      end
      win_valid <= 1'b0;
    end else begin
      win_valid <= accept_c && (row >= RW'(2)) && (col >= CW'(2));
      if (accept_c) begin
        lb1[col] <= pix_in;
        lb2[col] <= lb1[col];
        for (int ky = 0; ky < 3; ky++) begin
          win[ky][0] <= win[ky][1];
          win[ky][1] <= win[ky][2];
        end
        win[0][2] <= lb2[col];
        win[1][2] <= lb1[col];
        win[2][2] <= pix_in;
      end
    end
  end

  // Weight and bias storage, writable only between frames
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NTAP; i++) begin
        wt[i] <= '0;
      end
      bias <= '0;
    end else if (w_we && !busy) begin
      if (w_addr < AW'(NTAP)) begin
        wt[w_addr] <= w_data[WW-1:0];
      end else if (w_addr == AW'(NTAP)) begin
        bias <= w_data;
      end
    end
  end

  // S1: per-tap signed products
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NTAP; i++) begin
        s1_prod[i] <= '0;
      end
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= win_valid;
      for (int ch = 0; ch < CH; ch++) begin
        for (int ky = 0; ky < 3; ky++) begin
          for (int kx = 0; kx < 3; kx++) begin
            s1_prod[ch*9 + ky*3 + kx] <=
              PW'($signed({1'b0, win[ky][kx][ch*DW +: DW]})) * PW'(wt[ch*9 + ky*3 + kx]);
          end
        end
      end
    end
  end

  always_comb begin
    sum_c = bias;
    for (int i = 0; i < NTAP; i++) begin
      sum_c = sum_c + ACC_W'(s1_prod[i]);
    end
  end

  // S2: accumulate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_acc   <= '0;
      s2_valid <= 1'b0;
    end else begin
      s2_acc   <= sum_c;
      s2_valid <= s1_valid;
    end
  end

  // Round half up, scale, saturate; one extra bit keeps the rounding add from wrapping
  always_comb begin
    rnd_c     = (ACC_W+1)'(s2_acc) + $signed((ACC_W+1)'(RND));
    shifted_c = rnd_c >>> SHIFT;
    if (shifted_c < 0) begin
      sat_c = NEG_CLAMP;
    end else if (shifted_c > $signed((ACC_W+1)'(MAXV))) begin
      sat_c = DW'(MAXV);
    end else begin
      sat_c = DW'(shifted_c);
    end
  end

  // S3: output register, holds its value between results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_data <= sat_c;
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Bench for conv3x3_stream: table-driven constant cases plus random images checked
// against a direct arithmetic convolution model.
module tb_conv3x3_stream;

  localparam int unsigned IMG_W  = 28;
  localparam int unsigned IMG_H  = 28;
  localparam int unsigned CH     = 3;
  localparam int unsigned DW     = 8;
  localparam int unsigned WW     = 8;
  localparam int unsigned SHIFT  = 6;
  localparam int unsigned NTAP   = 9 * CH;
  localparam int unsigned ACC_W  = DW + WW + $clog2(NTAP) + 1;
  localparam int unsigned AW     = $clog2(NTAP + 1);
  localparam int          NPIX   = IMG_W * IMG_H;
  localparam int          NOUT   = (IMG_W - 2) * (IMG_H - 2);
  localparam int          BUDGET = 3 * NPIX + 100;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               busy;
  logic               w_we;
  logic [AW-1:0]      w_addr;
  logic [ACC_W-1:0]   w_data;
  logic               pix_valid;
  logic [CH*DW-1:0]   pix_in;
  logic               out_valid;
  logic [DW-1:0]      out_data;
  logic               done;

  conv3x3_stream #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .CH(CH), .DW(DW), .WW(WW), .SHIFT(SHIFT), .RELU(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .pix_valid(pix_valid), .pix_in(pix_in),
    .out_valid(out_valid), .out_data(out_data), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     wmode;
    int     wval;
    int     pix;
    longint bias;
    int     expv;
  } vec_t;

  vec_t   vecs [7];
  int     n_checks = 0;
  int     n_errors = 0;
  int     mw [NTAP];
  longint mbias;
  int     img [IMG_H][IMG_W][CH];
  int     exp_q [$];
  int     last_out;
  bit     pending_start;

  task automatic check(input string name, input longint act, input longint expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic write_w(input int addr, input longint data, input bit track);
    logic [ACC_W-1:0]        d;
    logic signed [WW-1:0]    t;
    logic signed [ACC_W-1:0] b;
    d = ACC_W'(data);
    @(negedge clk);
    w_we = 1'b1; w_addr = AW'(addr); w_data = d;
    @(negedge clk);
    w_we = 1'b0;
    if (track) begin
      if (addr < NTAP) begin
        t = d[WW-1:0];
        mw[addr] = int'(t);
      end else if (addr == NTAP) begin
        b = d;
        mbias = longint'(b);
      end
    end
  endtask

  // wmode 0: centre tap of channel 0 only; 1: all taps equal; 2: random small weights
  task automatic load_weights(input int wmode, input int wval, input longint bval);
    int v;
    for (int i = 0; i < NTAP; i++) begin
      if (wmode == 1)      v = wval;
      else if (wmode == 0) v = (i == 4) ? wval : 0;
      else                 v = int'($urandom_range(40)) - 20;
      write_w(i, longint'(v), 1'b1);
    end
    write_w(NTAP, bval, 1'b1);
    write_w(30, longint'($urandom_range(255)), 1'b0);
  endtask

  // mode 0: ramp (r*W+c)&255 on every channel; 1: constant; 2: random
  task automatic set_image(input int mode, input int val);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        for (int ch = 0; ch < CH; ch++)
          img[r][c][ch] = (mode == 0) ? ((r * IMG_W + c) & 255) :
                          (mode == 1) ? val : int'($urandom_range(255));
  endtask

  function automatic logic [CH*DW-1:0] pack(input int p);
    logic [CH*DW-1:0] px;
    px = '0;
    for (int ch = 0; ch < CH; ch++)
      px[ch*DW +: DW] = DW'(img[p / IMG_W][p % IMG_W][ch]);
    return px;
  endfunction

  task automatic build_expected();
    longint acc, v;
    exp_q.delete();
    for (int r = 0; r + 2 < IMG_H; r++) begin
      for (int c = 0; c + 2 < IMG_W; c++) begin
        acc = mbias;
        for (int ch = 0; ch < CH; ch++)
          for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++)
              acc += longint'(img[r+ky][c+kx][ch]) * longint'(mw[ch*9 + ky*3 + kx]);
        v = (acc + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        exp_q.push_back(int'(v));
      end
    end
  endtask

  task automatic run_frame(input bit gapped, input bit poke, input bit chain);
    int p = 0, iter = 0, drive22 = -1, first_out = -1, nout = 0;
    bit done_seen = 1'b0, fin = 1'b0, poked = 1'b0;
    build_expected();
    if (!pending_start) begin
      @(negedge clk);
      start = 1'b1;
    end
    pending_start = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", longint'(busy), 1);
    while (!fin && iter < BUDGET) begin
      if (out_valid) begin
        if (first_out < 0) first_out = iter;
        if (nout < exp_q.size()) check("out_data", longint'(out_data), longint'(exp_q[nout]));
        else check("extra_output", 1, 0);
        nout++;
        last_out = int'(out_data);
      end else begin
        check("out_hold", longint'(out_data), longint'(last_out));
      end
      if (done_seen) begin
        check("busy_after_done", longint'(busy), 0);
        fin = 1'b1;
      end else if (done) begin
        done_seen = 1'b1;
        check("done_with_last", longint'(out_valid && (nout == NOUT)), 1);
        check("busy_in_done", longint'(busy), 1);
      end
      start = 1'b0;
      w_we  = 1'b0;
      if (fin) begin
        pix_valid = 1'b0;
        if (chain) begin
          start = 1'b1;
          pending_start = 1'b1;
        end
      end else begin
        if (p < NPIX && !(gapped && (iter % 2 == 1))) begin
          pix_valid = 1'b1;
          pix_in    = pack(p);
          if (p == 2 * IMG_W + 2) drive22 = iter;
          p++;
        end else if (p >= NPIX) begin
          pix_valid = 1'b1;
          pix_in    = CH*DW'($urandom);
        end else begin
          pix_valid = 1'b0;
        end
        if (poke && !poked && p == NPIX / 2) begin
          poked  = 1'b1;
          start  = 1'b1;
          w_we   = 1'b1;
          w_addr = AW'(4);
          w_data = ACC_W'(99);
        end
        @(negedge clk);
        iter++;
      end
    end
    if (!fin) check("frame_timeout", 0, 1);
    check("out_count", longint'(nout), longint'(NOUT));
    check("first_latency", longint'(first_out - drive22), 4);
  endtask

  initial begin
    vecs[0] = '{wmode: 1, wval: 64,  pix: 5,  bias: 0,    expv: 135};
    vecs[1] = '{wmode: 1, wval: 64,  pix: 10, bias: 0,    expv: 255};
    vecs[2] = '{wmode: 0, wval: -64, pix: 50, bias: 0,    expv: 0};
    vecs[3] = '{wmode: 0, wval: 0,   pix: 0,  bias: 6400, expv: 100};
    vecs[4] = '{wmode: 0, wval: 32,  pix: 3,  bias: 0,    expv: 2};
    vecs[5] = '{wmode: 0, wval: 32,  pix: 1,  bias: 0,    expv: 1};
    vecs[6] = '{wmode: 0, wval: 32,  pix: 0,  bias: 0,    expv: 0};

    rst = 1'b1; start = 1'b0; w_we = 1'b0; w_addr = '0; w_data = '0;
    pix_valid = 1'b0; pix_in = '0;
    for (int i = 0; i < NTAP; i++) mw[i] = 0;
    mbias = 0; last_out = 0; pending_start = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", longint'(busy), 0);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_done", longint'(done), 0);
    check("rst_out_data", longint'(out_data), 0);
    rst = 1'b0;

    // Identity twice, second frame started the cycle after done
    load_weights(0, 64, 0);
    set_image(0, 0);
    run_frame(1'b0, 1'b0, 1'b1);
    run_frame(1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 7; i++) begin
      load_weights(vecs[i].wmode, vecs[i].wval, vecs[i].bias);
      set_image(1, vecs[i].pix);
      run_frame(1'b0, 1'b0, 1'b0);
      check($sformatf("vec%0d_out", i), longint'(last_out), longint'(vecs[i].expv));
    end

    // Random image and weights, back-to-back then gapped with mid-frame start/write
    load_weights(2, 0, longint'(int'($urandom_range(4000)) - 2000));
    set_image(2, 0);
    run_frame(1'b0, 1'b0, 1'b0);
    run_frame(1'b1, 1'b1, 1'b0);

    // Asynchronous reset part-way through a frame
    load_weights(0, 64, 0);
    set_image(0, 0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int p = 0; p < 300; p++) begin
      pix_valid = 1'b1;
      pix_in    = pack(p);
      @(negedge clk);
    end
    pix_valid = 1'b0;
    check("pre_rst_busy", longint'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", longint'(busy), 0);
    check("async_rst_out_valid", longint'(out_valid), 0);
    check("async_rst_done", longint'(done), 0);
    #1 rst = 1'b0;
    for (int i = 0; i < NTAP; i++) mw[i] = 0;
    mbias = 0; last_out = 0;
    run_frame(1'b0, 1'b0, 1'b0);
    check("post_rst_out", longint'(last_out), 0);
    load_weights(0, 64, 0);
    run_frame(1'b0, 1'b0, 1'b0);
    check("post_rst_identity_last", longint'(last_out), longint'(img[IMG_H-2][IMG_W-2][0]));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/conv3x3_stream.md
Name: conv3x3_stream

Overview:
Parametrised streaming 3x3 "valid" convolution over an IMG_W x IMG_H image with CH input channels, producing one output feature map. It is the successor to the fixed 28x28x3 first conv stage and adds run-time weight/bias loading, signed weights, bias, a rounding shift, an optional ReLU and saturation. It also adds a per-pixel valid input so the upstream source may stall. It sits between the image/feature source and the next pooling or conv stage.

Parameters:
IMG_W, 28, image width in pixels (>=3)
IMG_H, 28, image height in rows (>=3)
CH, 3, input channels per pixel
DW, 8, unsigned pixel and output width
WW, 8, signed weight width
SHIFT, 6, right shift applied to the accumulator; a weight of 1<<SHIFT means 1.0
RELU, 1, 1 = clamp negative results to 0; 0 = clamp to 0 anyway, since the output is unsigned. The parameter is kept for a future signed-output mode.
ACC_W, DW+WW+ceil(log2(9*CH))+1, signed accumulator width (localparam)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle pulse that starts a frame; accepted only in IDLE
busy  out  1  high from the start acceptance through the done cycle
w_we  in  1  weight/bias write strobe; ignored while busy
w_addr  in  ceil(log2(9*CH+1))  0..9*CH-1 selects weight (ch*9 + ky*3 + kx); 9*CH selects bias
w_data  in  ACC_W  signed; a weight write uses the low WW bits, a bias write uses all ACC_W bits
pix_valid  in  1  pix_in is valid this cycle
pix_in  in  CH*DW  one pixel, channel 0 in the LSBs, raster order
out_valid  out  1  out_data is valid this cycle
out_data  out  DW  convolution result
done  out  1  one-cycle pulse that accompanies the last result of the frame

Behaviour:
- Reset (async, any time): state=IDLE; busy, out_valid, done and out_data = 0; all counters, line buffers, window registers and pipeline registers = 0; all weights and bias = 0.
- States: IDLE -> RUN on start; RUN -> DRAIN on accepting pixel IMG_W*IMG_H-1; DRAIN -> IDLE after 3 cycles, with done in the final one.
- pix_valid is ignored in IDLE and DRAIN. start is ignored when not IDLE. A write with w_we and w_addr > 9*CH is ignored.
- Pixel acceptance is pix_valid && state==RUN. Acceptance advances col (0..IMG_W-1, wraps and increments row) and row (0..IMG_H-1).
- Two line buffers of IMG_W pixels each hold rows r-1 and r-2. On each accept the 3x3xCH window shifts left by one column and takes the new column {linebuf2[col], linebuf1[col], pix_in}.
- The window is valid when the accepted pixel has row>=2 and col>=2. The result for that window is the output at (row-2, col-2).
- Pipeline, 3 stages, free-running with a valid bit carried per stage:
  - S1: 9*CH signed products (DW+1 bits x WW bits).
  - S2: sum of all products plus bias, in ACC_W bits.
  - S3: add 1<<(SHIFT-1) (round half up), arithmetic shift right by SHIFT, clamp to [0, 2^DW-1], register to out_data.
- Latency: a window-completing pixel accepted at edge k produces out_valid=1 after edge k+3, for one cycle.
- Input gaps do not stall the pipeline; a bubble simply produces no out_valid.
- When out_valid=0, out_data holds its last value.
- Exactly (IMG_W-2)*(IMG_H-2) out_valid pulses per frame, in raster order. No output is produced for windows that wrap across a row boundary (col<2).
- done coincides with the last out_valid. busy falls the cycle after done. A start in the cycle after done is accepted.
- Weights and bias persist across frames until rewritten or reset.

Test Plan:
- Identity: weight[4]=64, all others and bias 0, pixel(r,c)=(r*28+c)&255 on every channel, back-to-back -> 676 outputs, out(r,c)=pixel(r+1,c+1), first out_valid 3 cycles after accepting pixel (2,2), single done with the last output.
- Saturation: all 27 weights=64, all pixels=5 -> every output 135; all pixels=10 -> every output 255.
- Sign/ReLU/bias: weight[4]=-64, pixels=50, bias=0 -> all outputs 0; all weights 0, bias=6400 -> all outputs 100.
- Rounding: weight[4]=32, pixels=3 -> 2 (1.5 rounds up); pixels=1 -> 1; pixels=0 -> 0.
- Gapped input: pix_valid high every other cycle, random pixels -> output sequence identical to the back-to-back run, 676 pulses; start and w_we asserted mid-frame -> no effect.
- Reset after 300 accepted pixels -> busy, out_valid and done drop without waiting for a clock edge; weights read back as 0 (identity test now yields all 0); a new start then completes a full frame normally.
